kws_layer_sequencer: RTL and testbench

Parametrised layer sequencer and PSRAM bus owner for the KWS accelerator. It runs up to NUM_LAYERS layer engines (conv, fc, maxpool, softmax, ...) in index order and skips layers cleared in a runtime mask. Each layer gets a one-cycle start pulse and is then awaited on its done signal, with a per-layer timeout watchdog. The shared QSPI PSRAM pins are routed to the active engine, and a ce_n-high recovery gap is enforced between layers.

---
 rtl/kws_pkg.sv | 19 +
 rtl/kws_next_layer_finder.sv | 26 ++
 rtl/kws_layer_sequencer.sv | 179 +++++++++++++++++
 tb/tb_kws_layer_sequencer.sv | 341 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/kws_pkg.sv
// Shared types and constants for the KWS accelerator layer sequencer.
package kws_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LAUNCH = 3'd1,
    RUN    = 3'd2,
    GAP    = 3'd3,
    FINISH = 3'd4,
    ERROR  = 3'd5
  } seq_state_t;

  // Value driven on the PSRAM pads whenever no engine owns the bus.
  localparam logic       PSRAM_SCK_IDLE  = 1'b0;
  localparam logic       PSRAM_CE_N_IDLE = 1'b1;
  localparam logic [3:0] PSRAM_OE_IDLE   = 4'h0;
  localparam logic [3:0] PSRAM_DOUT_IDLE = 4'h0;

endpackage

// File: rtl/kws_next_layer_finder.sv
// Finds the lowest enabled layer at/above (include_current=1) or strictly
// above (include_current=0) a given index. Purely combinational.
module kws_next_layer_finder #(
  parameter int NUM_LAYERS = 4,
  parameter int LIDX_W     = 2
) (
  input  logic [NUM_LAYERS-1:0] mask,
  input  logic [LIDX_W-1:0]     cur,
  input  logic                  include_current,
  output logic                  found,
  output logic [LIDX_W-1:0]     next_idx
);

  // Scan from the top down so the lowest qualifying index is written last.
  always_comb begin
    found    = 1'b0;
    next_idx = '0;
    for (int i = NUM_LAYERS - 1; i >= 0; i--) begin
      if (mask[i] && ((i > int'(cur)) || (include_current && (i == int'(cur))))) begin
        found    = 1'b1;
        next_idx = LIDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/kws_layer_sequencer.sv
// Runs the enabled layer engines in index order, owns the shared QSPI PSRAM
// pads, enforces an idle-bus gap between layers and a per-layer watchdog.
module kws_layer_sequencer
  import kws_pkg::*;
#(
  parameter int NUM_LAYERS = 4,
  parameter int LIDX_W     = (NUM_LAYERS > 1) ? $clog2(NUM_LAYERS) : 1,
  parameter int TO_W       = 24,
  parameter int GAP_CYCLES = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic                    abort,
  input  logic [NUM_LAYERS-1:0]   layer_en_mask,
  input  logic [TO_W-1:0]         timeout_cycles,
  output logic                    busy,
  output logic                    done,
  output logic                    error,
  output logic [LIDX_W-1:0]       err_layer,
  output logic [LIDX_W-1:0]       active_layer,
  output logic [NUM_LAYERS-1:0]   layer_start,
  input  logic [NUM_LAYERS-1:0]   layer_done,
  input  logic [NUM_LAYERS-1:0]   l_psram_sck,
  input  logic [NUM_LAYERS-1:0]   l_psram_ce_n,
  input  logic [4*NUM_LAYERS-1:0] l_psram_douten,
  input  logic [4*NUM_LAYERS-1:0] l_psram_dout,
  output logic                    psram_sck,
  output logic                    psram_ce_n,
  output logic [3:0]              psram_douten,
  output logic [3:0]              psram_dout,
  input  logic [3:0]              psram_din,
  output logic [3:0]              l_psram_din
);

  localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  seq_state_t            state, state_d;
  logic [NUM_LAYERS-1:0] mask_q, mask_d;
  logic [LIDX_W-1:0]     active_d, err_layer_d;
  logic [TO_W-1:0]       timer, timer_d;
  logic [GAP_W-1:0]      gap_cnt, gap_d;
  logic                  error_d;

  logic                  selecting;
  logic [NUM_LAYERS-1:0] find_mask;
  logic [LIDX_W-1:0]     find_cur;
  logic                  find_found;
  logic [LIDX_W-1:0]     find_idx;

  // While waiting for a start the finder looks at the live mask from index 0;
  // during a run it searches the latched mask strictly above the current layer.
  assign selecting = (state == IDLE) || (state == ERROR);
  assign find_mask = selecting ? layer_en_mask : mask_q;
  assign find_cur  = selecting ? '0 : active_layer;

  kws_next_layer_finder #(
    .NUM_LAYERS(NUM_LAYERS),
    .LIDX_W    (LIDX_W)
  ) u_finder (
    .mask           (find_mask),
    .cur            (find_cur),
    .include_current(selecting),
    .found          (find_found),
    .next_idx       (find_idx)
  );

  assign l_psram_din = psram_din;

  // State and control registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      mask_q       <= '0;
      active_layer <= '0;
      timer        <= '0;
      gap_cnt      <= '0;
      error        <= 1'b0;
      err_layer    <= '0;
    end else begin
      state        <= state_d;
      mask_q       <= mask_d;
      active_layer <= active_d;
      timer        <= timer_d;
      gap_cnt      <= gap_d;
      error        <= error_d;
      err_layer    <= err_layer_d;
    end
  end

  // Next-state logic and the state-decoded control outputs.
  always_comb begin
    state_d     = state;
    mask_d      = mask_q;
    active_d    = active_layer;
    timer_d     = timer;
    gap_d       = gap_cnt;
    error_d     = error;
    err_layer_d = err_layer;
    busy        = (state == LAUNCH) || (state == RUN) || (state == GAP) || (state == FINISH);
    done        = (state == FINISH);
    layer_start = (state == LAUNCH) ? (NUM_LAYERS'(1) << active_layer) : '0;

    case (state)
      IDLE, ERROR: begin
        if (start) begin
          error_d = 1'b0;
          mask_d  = layer_en_mask;
          if (find_found) begin
            active_d = find_idx;
            state_d  = LAUNCH;
          end else begin
            state_d = FINISH;
          end
        end
      end
      LAUNCH: begin
        timer_d = '0;
        state_d = RUN;
      end
      RUN: begin
        timer_d = timer + TO_W'(1);
        if (layer_done[active_layer]) begin
          if (!find_found) begin
            state_d = FINISH;
          end else if (GAP_CYCLES == 0) begin
            active_d = find_idx;
            state_d  = LAUNCH;
          end else begin
            gap_d   = '0;
            state_d = GAP;
          end
        end else if ((timeout_cycles != '0) && (timer == timeout_cycles - TO_W'(1))) begin
          error_d     = 1'b1;
          err_layer_d = active_layer;
          state_d     = ERROR;
        end
      end
      GAP: begin
        if (gap_cnt == GAP_W'(GAP_CYCLES - 1)) begin
          active_d = find_idx;
          state_d  = LAUNCH;
        end else begin
          gap_d = gap_cnt + GAP_W'(1);
        end
      end
      FINISH: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // abort overrides every other decision, including a start taken from ERROR.
    if (abort && (state != IDLE)) begin
      state_d     = IDLE;
      error_d     = 1'b0;
      err_layer_d = err_layer;
      active_d    = active_layer;
      mask_d      = mask_q;
    end
  end

  // Pad mux: only the RUN-state owner reaches the pins, select is registered.
  always_comb begin
    psram_sck    = PSRAM_SCK_IDLE;
    psram_ce_n   = PSRAM_CE_N_IDLE;
    psram_douten = PSRAM_OE_IDLE;
    psram_dout   = PSRAM_DOUT_IDLE;
    if (state == RUN) begin
      psram_sck    = l_psram_sck[active_layer];
      psram_ce_n   = l_psram_ce_n[active_layer];
      psram_douten = l_psram_douten[{active_layer, 2'b00} +: 4];
      psram_dout   = l_psram_dout[{active_layer, 2'b00} +: 4];
    end
  end

endmodule

// File: tb/tb_kws_layer_sequencer.sv
// Scoreboard bench for kws_layer_sequencer: a timeline model predicts the
// start/done/error events and the bus owner for every cycle of each run.
module tb_kws_layer_sequencer;

  localparam int N   = 4;
  localparam int LW  = 2;
  localparam int TW  = 24;
  localparam int GAP = 2;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            start = 1'b0;
  logic            abort = 1'b0;
  logic [N-1:0]    layer_en_mask = '0;
  logic [TW-1:0]   timeout_cycles = '0;
  logic            busy, done, error;
  logic [LW-1:0]   err_layer, active_layer;
  logic [N-1:0]    layer_start;
  logic [N-1:0]    layer_done = '0;
  logic [N-1:0]    l_sck = '0;
  logic [N-1:0]    l_ce_n = '1;
  logic [4*N-1:0]  l_oe = '0;
  logic [4*N-1:0]  l_dout = '0;
  logic            psram_sck, psram_ce_n;
  logic [3:0]      psram_douten, psram_dout, l_psram_din;
  logic [3:0]      psram_din = '0;

  kws_layer_sequencer #(
    .NUM_LAYERS(N), .LIDX_W(LW), .TO_W(TW), .GAP_CYCLES(GAP)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .layer_en_mask(layer_en_mask), .timeout_cycles(timeout_cycles),
    .busy(busy), .done(done), .error(error), .err_layer(err_layer),
    .active_layer(active_layer), .layer_start(layer_start), .layer_done(layer_done),
    .l_psram_sck(l_sck), .l_psram_ce_n(l_ce_n), .l_psram_douten(l_oe),
    .l_psram_dout(l_dout), .psram_sck(psram_sck), .psram_ce_n(psram_ce_n),
    .psram_douten(psram_douten), .psram_dout(psram_dout), .psram_din(psram_din),
    .l_psram_din(l_psram_din)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int kind; int idx; int cyc; } ev_t;   // kind: 0 start, 1 done, 2 error
  ev_t      q[$];
  int       owner[int];
  bit       busy_m[int];
  int       lim;
  int       dly[N];
  bit [N-1:0] run_mask = '0;
  bit       chk_en = 1'b0;
  int       errors = 0;
  int       checks = 0;
  int       cnt[N];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic void push_ev(int k, int i, int c);
    ev_t e;
    if (c <= lim) begin
      e.kind = k; e.idx = i; e.cyc = c;
      q.push_back(e);
    end
  endfunction

  function automatic void set_busy(int c);
    if (c <= lim) busy_m[c] = 1'b1;
  endfunction

  function automatic void set_own(int c, int o);
    if (c <= lim) begin
      owner[c]  = o;
      busy_m[c] = 1'b1;
    end
  endfunction

  // Timeline of one run started in cycle s: layers launch one after another,
  // each owning the bus from launch+1 until its done (or until timeout).
  function automatic void model(int s, bit [N-1:0] m, int tmo);
    int t;
    int last;
    int l;
    t = s + 1;
    last = -1;
    for (int i = 0; i < N; i++) if (m[i]) last = i;
    if (m == '0) begin
      push_ev(1, 0, s + 1);
      set_busy(s + 1);
      return;
    end
    for (int i = 0; i < N; i++) begin
      if (m[i]) begin
        l = t;
        push_ev(0, i, l);
        set_busy(l);
        if (dly[i] > 0 && (tmo == 0 || dly[i] <= tmo)) begin
          for (int c = l + 1; c <= l + dly[i]; c++) set_own(c, i);
          if (i == last) begin
            push_ev(1, 0, l + dly[i] + 1);
            set_busy(l + dly[i] + 1);
            return;
          end
          for (int c = l + dly[i] + 1; c <= l + dly[i] + GAP; c++) set_busy(c);
          t = l + dly[i] + 1 + GAP;
        end else begin
          for (int c = l + 1; c <= l + tmo; c++) set_own(c, i);
          push_ev(2, i, l + tmo + 1);
          return;
        end
      end
    end
  endfunction

  // Engine models: random pad activity every cycle, done dly[i] cycles after start;
  // layers outside the run mask toggle done at random.
  initial begin
    bit d;
    forever begin
      @(posedge clk); #2;
      for (int i = 0; i < N; i++) begin
        l_sck[i]        = 1'($urandom);
        l_ce_n[i]       = 1'($urandom);
        l_oe[4*i +: 4]  = 4'($urandom);
        l_dout[4*i +: 4] = 4'($urandom);
      end
      psram_din = 4'($urandom);
      for (int i = 0; i < N; i++) begin
        d = 1'b0;
        if (!rst_n) cnt[i] = 0;
        if (cnt[i] > 0) begin
          cnt[i]--;
          if (cnt[i] == 0) d = 1'b1;
        end
        if (layer_start[i] && dly[i] > 0) cnt[i] = dly[i];
        if (!run_mask[i]) d = 1'($urandom_range(0, 1));
        layer_done[i] = d;
      end
    end
  end

  // Monitor: pops expected events whenever the DUT shows one, checks the bus every cycle.
  initial begin
    ev_t e;
    int c;
    int o;
    logic [9:0] exp_pad;
    bit prev_err;
    prev_err = 1'b0;
    forever begin
      @(negedge clk);
      if (chk_en) begin
        c = cyc;
        if (layer_start != '0) begin
          if (q.size() == 0) chk("start_unexpected", layer_start, 0);
          else begin
            e = q.pop_front();
            chk("start_kind", e.kind, 0);
            chk("start_onehot", layer_start, N'(1) << e.idx);
            chk("start_cycle", c, e.cyc);
          end
        end
        if (done) begin
          if (q.size() == 0) chk("done_unexpected", done, 0);
          else begin
            e = q.pop_front();
            chk("done_kind", e.kind, 1);
            chk("done_cycle", c, e.cyc);
          end
        end
        if (error && !prev_err) begin
          if (q.size() == 0) chk("error_unexpected", error, 0);
          else begin
            e = q.pop_front();
            chk("error_kind", e.kind, 2);
            chk("error_cycle", c, e.cyc);
            chk("err_layer", err_layer, e.idx);
          end
        end
        if (owner.exists(c)) begin
          o = owner[c];
          exp_pad = {l_sck[o], l_ce_n[o], l_oe[4*o +: 4], l_dout[4*o +: 4]};
          chk("active_layer", active_layer, o);
        end else begin
          exp_pad = {1'b0, 1'b1, 4'h0, 4'h0};
        end
        chk("pads", {psram_sck, psram_ce_n, psram_douten, psram_dout}, exp_pad);
        chk("busy", busy, busy_m.exists(c));
        chk("din_bcast", l_psram_din, psram_din);
      end
      prev_err = error;
    end
  end

  task automatic launch(input bit [N-1:0] m, input int tmo, input int abort_rel, output int s);
    @(posedge clk); #2;
    start = 1'b1;
    layer_en_mask = m;
    timeout_cycles = TW'(tmo);
    run_mask = m;
    s = cyc;
    lim = (abort_rel < 0) ? 32'h7fffffff : s + abort_rel;
    model(s, m, tmo);
    @(posedge clk); #2;
    start = 1'b0;
    layer_en_mask = N'($urandom);
    @(negedge clk);
    chk("error_cleared_by_start", error, 0);
    if (abort_rel >= 0) begin
      while (cyc != s + abort_rel) begin
        @(posedge clk); #2;
      end
      abort = 1'b1;
      @(posedge clk); #2;
      abort = 1'b0;
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (q.size() != 0 && n < 3000) begin
      @(posedge clk);
      n++;
    end
    chk("drain_pending", q.size(), 0);
    q.delete();
    repeat (4) @(posedge clk);
  endtask

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "bench timed out");
  end

  initial begin
    int s;
    int tmo;
    int ab;
    bit [N-1:0] m;
    for (int i = 0; i < N; i++) begin dly[i] = 0; cnt[i] = 0; end
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_error", error, 0);
    chk("rst_layer_start", layer_start, 0);
    chk("rst_active", active_layer, 0);
    chk("rst_err_layer", err_layer, 0);
    chk("rst_ce_n", psram_ce_n, 1);
    @(posedge clk); #3;
    rst_n = 1'b1;
    chk_en = 1'b1;

    // All layers, each done 10 cycles after its start; a second start mid-run is ignored.
    for (int i = 0; i < N; i++) dly[i] = 10;
    launch(4'b1111, 0, -1, s);
    @(posedge clk); #2;
    start = 1'b1; layer_en_mask = 4'b0000;
    @(posedge clk); #2;
    start = 1'b0;
    drain();

    // Sparse mask: disabled engines toggle done and ce_n but never surface.
    dly[0] = 3; dly[1] = 4; dly[2] = 2; dly[3] = 6;
    launch(4'b1010, 0, -1, s);
    drain();

    // Empty mask.
    launch(4'b0000, 0, -1, s);
    drain();

    // Watchdog: layer 1 done exactly at the limit, layer 2 never done.
    dly[0] = 4; dly[1] = 5; dly[2] = 0; dly[3] = 3;
    launch(4'b1111, 5, -1, s);
    drain();
    @(negedge clk);
    chk("error_sticky", error, 1);
    chk("err_layer_held", err_layer, 2);
    chk("error_not_busy", busy, 0);

    // Restart from ERROR clears the flag and begins at layer 0.
    for (int i = 0; i < N; i++) dly[i] = 2;
    launch(4'b1111, 5, -1, s);
    drain();

    // Abort in the third RUN cycle of layer 1, same cycle as its done.
    dly[0] = 2; dly[1] = 3; dly[2] = 5; dly[3] = 5;
    launch(4'b1111, 0, 9, s);
    drain();

    // Asynchronous reset between edges in the middle of layer 1.
    for (int i = 0; i < N; i++) dly[i] = 10;
    launch(4'b1111, 0, -1, s);
    repeat (16) @(posedge clk);
    @(negedge clk);
    chk_en = 1'b0;
    #3;
    rst_n = 1'b0;
    #1;
    chk("arst_busy", busy, 0);
    chk("arst_layer_start", layer_start, 0);
    chk("arst_active", active_layer, 0);
    chk("arst_ce_n", psram_ce_n, 1);
    chk("arst_sck", psram_sck, 0);
    chk("arst_oe", psram_douten, 0);
    chk("arst_done", done, 0);
    q.delete(); owner.delete(); busy_m.delete();
    @(posedge clk); #3;
    rst_n = 1'b1;
    chk_en = 1'b1;
    for (int i = 0; i < N; i++) dly[i] = 3;
    launch(4'b0110, 0, -1, s);
    drain();

    // Randomised runs with optional watchdog and abort.
    for (int r = 0; r < 14; r++) begin
      m = N'($urandom);
      tmo = ($urandom_range(0, 2) == 0) ? 0 : $urandom_range(2, 14);
      for (int i = 0; i < N; i++) begin
        dly[i] = $urandom_range(1, 12);
        if (tmo != 0 && $urandom_range(0, 3) == 0) dly[i] = 0;
      end
      ab = ($urandom_range(0, 3) == 0) ? $urandom_range(3, 30) : -1;
      launch(m, tmo, ab, s);
      drain();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
